// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared counter; register access answers one cycle after req, outputs lag counter by one cycle.
// Never stalls: gnt_o follows req_i and a request may be issued every cycle.
module pwm_multi #(
    parameter int NumChannels = 4,
    parameter int CntWidth    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    output logic                   gnt_o,
    input  logic [31:0]            addr_i,
    input  logic                   we_i,
    input  logic [3:0]             be_i,
    input  logic [31:0]            wdata_i,
    output logic                   valid_o,
    output logic [31:0]            rdata_o,
    output logic                   err_o,
    output logic [NumChannels-1:0] cio_pwm_o,
    output logic [NumChannels-1:0] cio_pwm_en_o
);

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    // Staging (bus-visible) registers
    logic                   en;
    logic                   ca_stg;
    logic [CntWidth-1:0]    period_stg;
    logic [NumChannels-1:0] ch_en;
    logic [NumChannels-1:0] invert;
    logic [CntWidth-1:0]    duty_stg [NumChannels];

    // Active copies used by the counter and comparators
    logic                   ca_act;
    logic [CntWidth-1:0]    period_act;
    logic [CntWidth-1:0]    duty_act [NumChannels];

    logic [CntWidth-1:0]    cnt, cnt_nxt;
    dir_e                   dir, dir_nxt;
    logic                   bnd;
    logic [CntWidth-1:0]    p_eff, pm1;
    logic [NumChannels-1:0] raw;

    logic [3:0]             offset;
    logic                   addr_ok;
    logic [NumChannels-1:0] duty_hit;
    logic [31:0]            rd_val;
    logic [31:0]            wr_val;
    logic                   wr;
    logic                   unused_bits;

    function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    assign gnt_o       = req_i;
    assign offset      = addr_i[5:2];
    assign unused_bits = ^{addr_i[31:6], addr_i[1:0], wr_val};

    // Register decode; rd_val is also the current value merged with byte-enabled write data
    always_comb begin
        rd_val   = '0;
        addr_ok  = 1'b1;
        duty_hit = '0;
        case (offset)
            4'h0: rd_val = 32'({ca_stg, en});
            4'h1: rd_val = 32'(period_stg);
            4'h2: rd_val = 32'(ch_en);
            4'h3: rd_val = 32'(invert);
            4'h4: rd_val = 32'(cnt);
            default: begin
                addr_ok = 1'b0;
                for (int i = 0; i < NumChannels; i++) begin
                    if (offset == 4'(8 + i)) begin
                        addr_ok     = 1'b1;
                        duty_hit[i] = 1'b1;
                        rd_val      = 32'(duty_stg[i]);
                    end
                end
            end
        endcase
    end

    assign wr_val = merge_be(rd_val, wdata_i, be_i);
    assign wr     = req_i & we_i & addr_ok;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            en         <= 1'b0;
            ca_stg     <= 1'b0;
            period_stg <= '0;
            ch_en      <= '0;
            invert     <= '0;
            for (int i = 0; i < NumChannels; i++) duty_stg[i] <= '0;
        end else if (wr) begin
            case (offset)
                4'h0: {ca_stg, en} <= wr_val[1:0];
                4'h1: period_stg   <= wr_val[CntWidth-1:0];
                4'h2: ch_en        <= wr_val[NumChannels-1:0];
                4'h3: invert       <= wr_val[NumChannels-1:0];
                default: begin
                    for (int i = 0; i < NumChannels; i++) begin
                        if (duty_hit[i]) duty_stg[i] <= wr_val[CntWidth-1:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            valid_o <= req_i;
            err_o   <= req_i & ~addr_ok;
            rdata_o <= (req_i && !we_i && addr_ok) ? rd_val : '0;
        end
    end

    assign p_eff = (period_act == '0) ? CntWidth'(1) : period_act;
    assign pm1   = p_eff - CntWidth'(1);

    // Counter / direction state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt <= '0;
            dir <= DirUp;
        end else begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
        end
    end

    // Next-state logic; bnd marks the cycle in which active copies reload
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        bnd     = 1'b0;
        if (!en) begin
            cnt_nxt = '0;
            dir_nxt = DirUp;
        end else if (!ca_act) begin
            dir_nxt = DirUp;
            if (cnt >= pm1) begin
                bnd     = 1'b1;
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + CntWidth'(1);
            end
        end else if (dir == DirUp) begin
            if (cnt >= pm1) dir_nxt = DirDown;
            else            cnt_nxt = cnt + CntWidth'(1);
        end else begin
            if (cnt == '0) begin
                dir_nxt = DirUp;
                bnd     = 1'b1;
            end else begin
                cnt_nxt = cnt - CntWidth'(1);
            end
        end
        // A mode switch taking effect restarts the waveform from the bottom
        if (en && bnd && (ca_stg != ca_act)) begin
            cnt_nxt = '0;
            dir_nxt = DirUp;
        end
    end

    // Output logic: per-channel compare against the active duty
    always_comb begin
        raw = '0;
        for (int i = 0; i < NumChannels; i++) raw[i] = (cnt < duty_act[i]);
    end

    // Staging reads the pre-write value, so a write in the boundary cycle waits a period
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ca_act     <= 1'b0;
            period_act <= '0;
            for (int i = 0; i < NumChannels; i++) duty_act[i] <= '0;
        end else if (!en || bnd) begin
            ca_act     <= ca_stg;
            period_act <= period_stg;
            for (int i = 0; i < NumChannels; i++) duty_act[i] <= duty_stg[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cio_pwm_o    <= '0;
            cio_pwm_en_o <= '0;
        end else begin
            cio_pwm_o    <= (raw ^ invert) & ch_en & {NumChannels{en}};
            cio_pwm_en_o <= ch_en & {NumChannels{en}};
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (4 channels, 32-bit counter); inputs driven and outputs sampled at negedge.
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        valid;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  pwm;
    logic [3:0]  pwm_en;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;
    logic        er;
    int          j;

    pwm_multi #(.NumChannels(4), .CntWidth(32)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .gnt_o       (gnt),
        .addr_i      (addr),
        .we_i        (we),
        .be_i        (be),
        .wdata_i     (wdata),
        .valid_o     (valid),
        .rdata_o     (rdata),
        .err_o       (err),
        .cio_pwm_o   (pwm),
        .cio_pwm_en_o(pwm_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One access: issued at a negedge, accepted at the next posedge, response sampled at the following negedge
    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(posedge clk);
        @(negedge clk);
        rd = rdata; er = err;
        chk("valid", 32'(valid), 32'd1);
        req = 1'b0; we = 1'b0; be = '0;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, a, 4'hf, d);
    endtask

    function automatic int sh_duty(input int jj);
        return (jj <= 8) ? 2 : ((jj <= 32) ? 6 : 3);
    endfunction

    initial begin
        logic [5:0] ca_pat;
        ca_pat = 6'b100001;   // bit k = expected ch0 at step k (cnt 0,1,2,2,1,0)

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pwm", 32'(pwm), 32'd0);
        chk("rst_pwm_en", 32'(pwm_en), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Edge mode, P=4
        req = 1'b1; we = 1'b0; addr = 32'h0;
        #1 chk("gnt", 32'(gnt), 32'd1);
        req = 1'b0;
        @(negedge clk);
        wr32(32'h04, 32'd4);
        wr32(32'h20, 32'd1);
        wr32(32'h24, 32'd0);
        wr32(32'h28, 32'd9);
        wr32(32'h08, 32'h7);
        wr32(32'h00, 32'h1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("edge_ch0", 32'(pwm[0]), 32'((i % 4) == 0));
            chk("edge_ch1_duty0", 32'(pwm[1]), 32'd0);
            chk("edge_ch2_duty9", 32'(pwm[2]), 32'd1);
        end
        chk("edge_pwm_en", 32'(pwm_en), 32'h7);
        @(negedge clk);
        bus(1'b0, 32'h10, 4'h0, 32'h0);
        chk("count_read", rd, 32'd1);
        chk("count_err", 32'(er), 32'd0);
        @(negedge clk);
        chk("valid_drop", 32'(valid), 32'd0);

        // Invert channel 0
        wr32(32'h00, 32'h0);
        wr32(32'h0c, 32'h1);
        wr32(32'h00, 32'h1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("inv_ch0", 32'(pwm[0]), 32'((i % 4) != 0));
        end
        wr32(32'h0c, 32'h0);

        // Center mode, P=3
        wr32(32'h00, 32'h0);
        wr32(32'h04, 32'd3);
        wr32(32'h20, 32'd1);
        wr32(32'h00, 32'h2);
        wr32(32'h00, 32'h3);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("ca_ch0", 32'(pwm[0]), 32'(ca_pat[i % 6]));
        end

        // Shadowing, P=8: mid-period write and boundary-cycle write
        wr32(32'h00, 32'h0);
        wr32(32'h04, 32'd8);
        wr32(32'h20, 32'd2);
        wr32(32'h00, 32'h1);
        j = 0;
        while (j < 40) begin
            if (j == 2 || j == 23) begin
                wr32(32'h20, (j == 2) ? 32'd6 : 32'd3);
            end else begin
                @(negedge clk);
            end
            j++;
            chk("shadow_ch0", 32'(pwm[0]), 32'(((j - 1) % 8) < sh_duty(j)));
        end

        // Channel disable
        wr32(32'h24, 32'd9);
        repeat (16) @(negedge clk);
        chk("ch1_high", 32'(pwm[1]), 32'd1);
        wr32(32'h08, 32'h5);
        chk("ch1_first_cycle", 32'(pwm[1]), 32'd1);
        chk("ch1_en_first_cycle", 32'(pwm_en[1]), 32'd1);
        @(negedge clk);
        chk("ch1_off", 32'(pwm[1]), 32'd0);
        chk("ch1_en_off", 32'(pwm_en[1]), 32'd0);

        // PERIOD=0 behaves as 1
        wr32(32'h00, 32'h0);
        wr32(32'h04, 32'd0);
        wr32(32'h00, 32'h1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("p0_ch0", 32'(pwm[0]), 32'd1);
        end

        // Bus behaviour
        wr32(32'h00, 32'h0);
        bus(1'b1, 32'h04, 4'b0010, 32'h12345678);
        chk("be_err", 32'(er), 32'd0);
        bus(1'b0, 32'h04, 4'h0, 32'h0);
        chk("be_readback", rd, 32'h00005600);
        bus(1'b0, 32'h14, 4'h0, 32'h0);
        chk("bad14_err", 32'(er), 32'd1);
        chk("bad14_rdata", rd, 32'd0);
        bus(1'b0, 32'h30, 4'h0, 32'h0);
        chk("bad30_err", 32'(er), 32'd1);
        chk("bad30_rdata", rd, 32'd0);
        bus(1'b0, 32'h2c, 4'h0, 32'h0);
        chk("duty3_err", 32'(er), 32'd0);
        bus(1'b1, 32'h10, 4'hf, 32'hffff_ffff);
        chk("count_wr_err", 32'(er), 32'd0);
        bus(1'b0, 32'h10, 4'h0, 32'h0);
        chk("count_wr_noeffect", rd, 32'd0);
        bus(1'b0, 32'h20, 4'h0, 32'h0);
        chk("duty0_read", rd, 32'd3);

        // Reset asserted mid-run
        wr32(32'h00, 32'h1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_pwm", 32'(pwm), 32'd0);
        chk("mrst_pwm_en", 32'(pwm_en), 32'd0);
        chk("mrst_valid", 32'(valid), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 5 || i >= 8) begin
                bus(1'b0, (i < 5) ? 32'(4 * i) : 32'(32 + 4 * (i - 8)), 4'h0, 32'h0);
                chk("mrst_reg", rd, 32'd0);
            end
        end
        @(negedge clk);
        chk("mrst_pwm_after", 32'(pwm), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM peripheral replacing the fixed two-channel `pwm` on the main bus. It provides `NumChannels` outputs driven by one shared counter of `CntWidth` bits, with edge-aligned or center-aligned modes and per-channel enable and invert. Period, duty and mode writes are double-buffered and take effect only at a period boundary. It sits behind the crossbar on the codebase's req/gnt register port.

## Interface
- `NumChannels`, default 4: number of PWM outputs, range 1..8.
- `CntWidth`, default 16: width of the counter, PERIOD and DUTY, range 2..32.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous and active-low.
- `req_i` in 1: register access request.
- `gnt_o` out 1: grant. Equals `req_i` (the block is always ready).
- `addr_i` in 32: byte address. Bits [5:2] are decoded; bits [1:0] are ignored.
- `we_i` in 1: 1 = write, 0 = read.
- `be_i` in 4: byte enables for writes.
- `wdata_i` in 32: write data.
- `valid_o` out 1: response valid, one cycle after the grant.
- `rdata_o` out 32: read data, registered.
- `err_o` out 1: error response, qualified by `valid_o`.
- `cio_pwm_o` out NumChannels: PWM outputs, registered.
- `cio_pwm_en_o` out NumChannels: output enables, registered.

## Operation
- **Register map (word offsets).**
  - 0x00 CTRL: bit0 EN, bit1 CA (center-aligned).
  - 0x04 PERIOD.
  - 0x08 CH_EN.
  - 0x0C INVERT.
  - 0x10 COUNT: read-only. Writes are ignored with no error.
  - 0x20+4i DUTY[i], for i < NumChannels.
- Any other offset returns `err_o`=1 and `rdata_o`=0, and has no effect.
- Unimplemented bits read 0. Writes update only the bytes enabled by `be_i`.
- **Shadowing.** PERIOD, DUTY[] and CA are staging registers, each with an active copy.
  - When EN=0, the active copies load from staging every cycle.
  - When EN=1, the active copies load only in the boundary cycle. A write that lands in the boundary cycle is not used for that load; it takes effect at the next boundary.
  - CH_EN and INVERT are unshadowed and take effect immediately.
- An active PERIOD of 0 behaves as 1.
- **Edge mode (CA=0).**
  - Counter runs 0..P-1, then wraps to 0, giving a period of P cycles.
  - Boundary is the cycle with cnt==P-1.
- **Center mode (CA=1).**
  - Direction state is UP or DOWN.
  - In UP: if cnt==P-1, switch to DOWN and hold cnt; otherwise increment.
  - In DOWN: if cnt==0, switch to UP and hold cnt; this cycle is the boundary. Otherwise decrement.
  - Period is 2P cycles. Example for P=3: 0,1,2,2,1,0,0,...
- **Mode change.** A change of active CA applied at a boundary restarts the counter at cnt=0, direction UP.
- **Compare.** raw[i] = (cnt < DUTY[i]).
  - DUTY=0 gives constant low.
  - DUTY>=P gives constant high.
- **Outputs.**
  - `cio_pwm_o[i]` is registered: (raw[i] ^ INVERT[i]) & CH_EN[i] & EN.
  - `cio_pwm_en_o[i]` is registered: CH_EN[i] & EN.
- **EN=0.** Counter held at 0, direction UP, all outputs 0. Inversion is not applied.

## Timing
- Reset (`rst_ni` low at a clock edge) gives:
  - all registers 0, cnt=0, direction UP;
  - `cio_pwm_o`=0, `cio_pwm_en_o`=0;
  - `valid_o`=0, `rdata_o`=0, `err_o`=0.
- Reset asserted mid-period aborts immediately. There are no pending updates after reset.
- Register access:
  - request accepted in cycle N gives `valid_o`=1 in cycle N+1, for exactly one cycle per request;
  - back-to-back requests are allowed every cycle;
  - a write is visible to a read accepted in the following cycle.
- EN 0→1 written in cycle N: cnt=0 from cycle N+1, and the output reflects cnt=0 in cycle N+2. Output lags the counter by one cycle.
- EN 1→0 written in cycle N: outputs are 0 from cycle N+2.
- COUNT reads return the counter value in the accept cycle.

## Test plan
- **Reset.** Assert `rst_ni`=0 for 2 cycles mid-run → all outputs 0, COUNT reads 0, all registers read 0.
- **Edge mode.** P=4, DUTY0=1, CH_EN=1, EN=1 → `cio_pwm_o[0]` repeats 1,0,0,0. DUTY1=0 → ch1 constant 0. DUTY2=9 → ch2 constant 1. INVERT0=1 → ch0 repeats 0,1,1,1.
- **Center mode.** CA=1, P=3, DUTY0=1 → ch0 repeats 1,0,0,0,0,1, aligned with cnt sequence 0,1,2,2,1,0.
- **Shadowing.** While running with P=8, write DUTY0=6 at cnt=2 → the current period keeps the old duty; the next period is high for 6 cycles. A write landing in the boundary cycle applies one period later.
- **Bus.**
  - Write PERIOD=0x12345678 with `be_i`=4'b0010 (CntWidth=32) → reads back 0x00005600.
  - Read offset 0x14 → `err_o`=1, `rdata_o`=0.
  - Read offset 0x20+4*NumChannels → `err_o`=1, `rdata_o`=0.
  - Write COUNT → no effect, `err_o`=0.
- **Disable and limits.** Clear CH_EN bit 1 → ch1 output and enable both 0 on the second cycle. PERIOD=0 → behaves as P=1: with DUTY>0 the output is constant 1.
